sobel_window_gen: RTL

Streaming 3x3 window generator feeding the combinational Sobel core. Accepts one grayscale pixel per valid cycle in raster order, stores the two previous image lines in line buffers, and presents a registered 3x3 pixel window plus a valid strobe. The window is presented only for interior positions, so the core never sees partial windows. It sits between the grayscale converter and the Sobel core.

---
 rtl/sobel_window_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shifting window, valid only at interior positions.
// Optional macro SOBEL_WIN_EOF_EN adds frame_done_o, pulsing with the last window of each frame.
module sobel_window_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [PIXEL_WIDTH-1:0]                 pixel_i,
    input  logic                                   pixel_valid_i,
    input  logic                                   sof_i,
    output logic [0:2][0:2][PIXEL_WIDTH-1:0]       window_o,
    output logic                                   window_valid_o,
`ifdef SOBEL_WIN_EOF_EN
    output logic                                   frame_done_o,
`endif
    output logic [$clog2(IMG_HEIGHT)-1:0]          win_row_o,
    output logic [$clog2(IMG_WIDTH)-1:0]           win_col_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [PIXEL_WIDTH-1:0]           lb0_q [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0]           lb1_q [IMG_WIDTH];

    logic [0:2][0:2][PIXEL_WIDTH-1:0] window_d, window_q;
    logic                             win_valid_d, win_valid_q;
    logic [RW-1:0]                    win_row_d, win_row_q;
    logic [CW-1:0]                    win_col_d, win_col_q;
    logic [CW-1:0]                    col_d, col_q;
    logic [RW-1:0]                    row_d, row_q;
    logic [CW-1:0]                    eff_col;
    logic [RW-1:0]                    eff_row;
    logic                             frame_done_d, frame_done_q;

    always_comb begin
        eff_col      = sof_i ? '0 : col_q;
        eff_row      = sof_i ? '0 : row_q;
        window_d     = window_q;
        win_valid_d  = 1'b0;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (pixel_valid_i) begin
            for (int r = 0; r < 3; r++) begin
                window_d[r][0] = window_q[r][1];
                window_d[r][1] = window_q[r][2];
            end
            window_d[0][2] = lb1_q[eff_col];
            window_d[1][2] = lb0_q[eff_col];
            window_d[2][2] = pixel_i;
            // Only interior centres are presented; border pixels just fill the buffers.
            if (eff_row >= RW'(2) && eff_col >= CW'(2)) begin
                win_valid_d  = 1'b1;
                win_row_d    = eff_row - RW'(1);
                win_col_d    = eff_col - CW'(1);
                frame_done_d = (eff_row == RW'(IMG_HEIGHT - 1)) && (eff_col == CW'(IMG_WIDTH - 1));
            end
            if (eff_col == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (eff_row == RW'(IMG_HEIGHT - 1)) ? '0 : eff_row + RW'(1);
            end else begin
                col_d = eff_col + CW'(1);
                row_d = eff_row;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            window_q     <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            window_q     <= window_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffers carry no reset; stale entries are overwritten before any window can use them.
    always_ff @(posedge clk_i) begin
        if (pixel_valid_i) begin
            lb1_q[eff_col] <= lb0_q[eff_col];
            lb0_q[eff_col] <= pixel_i;
        end
    end

    assign window_o       = window_q;
    assign window_valid_o = win_valid_q;
    assign win_row_o      = win_row_q;
    assign win_col_o      = win_col_q;
`ifdef SOBEL_WIN_EOF_EN
    assign frame_done_o   = frame_done_q;
`else
    logic unused_fd;
    assign unused_fd = frame_done_q;
`endif

endmodule
